// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared constants and types for the instruction-fetch front end
package mips_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction-memory and IF/ID-side signals of the fetch queue
interface fetch_queue_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        hold;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_plus4_out;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, pc_plus4_out,
    input  imem_ack, imem_rdata, hold, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, pc_plus4_out,
    output imem_ack, imem_rdata, hold, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of fetched {pc_plus4, instr} entries
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fq_entry_t                  push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fq_entry_t                  head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t       mem_q [DEPTH];
  fq_entry_t       mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  // Flush wins over push/pop; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC owner, single-outstanding imem requester and IF/ID feed FIFO
// Optional same-cycle bypass of an ack into an empty queue: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  fetch_queue_if.master      fq
);

  localparam int             CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  fetch_state_t   state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    addr_q, addr_d;
  logic           req_q, req_d;

  fq_entry_t      head;
  fq_entry_t      push_data;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic           fifo_empty;
  logic           fifo_valid;
  logic           ack;
  logic           push;
  logic           fifo_pop;
  logic           bypass_hit;
  logic           bypass_pop;

  assign ack        = fq.imem_ack & req_q;
  assign fifo_valid = ~fifo_empty;
  assign fifo_pop   = fifo_valid & ~fq.hold & ~fq.redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = fifo_empty & (state_q == WAIT) & ack;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed entry that IF/ID accepts this cycle never touches the FIFO.
  assign bypass_pop = bypass_hit & ~fq.hold & ~fq.redirect;
  assign push       = (state_q == WAIT) & ack & ~fq.redirect & ~bypass_pop;
  assign count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, fifo_pop};

  assign push_data.pc_plus4 = pc_q + 32'd4;
  assign push_data.instr    = fq.imem_rdata;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (fq.redirect) begin
          pc_d = fq.redirect_pc;
        end else if (count < FULL_CNT) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      WAIT: begin
        if (fq.redirect) begin
          pc_d = fq.redirect_pc;
          if (ack) begin
            addr_d = fq.redirect_pc;
          end else begin
            state_d = DRAIN;
          end
        end else if (ack) begin
          pc_d = pc_q + 32'd4;
          if (count_next < FULL_CNT) begin
            addr_d = pc_q + 32'd4;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      DRAIN: begin
        // The outstanding response belongs to the abandoned path; swallow it.
        if (fq.redirect) begin
          pc_d = fq.redirect_pc;
        end
        if (ack) begin
          state_d = WAIT;
          addr_d  = fq.redirect ? fq.redirect_pc : pc_q;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .flush     (fq.redirect),
    .head      (head),
    .count     (count),
    .empty     (fifo_empty)
  );

  assign fq.imem_req     = req_q;
  assign fq.imem_addr    = addr_q;
  assign fq.inst_valid   = fifo_valid | bypass_hit;
  assign fq.inst_out     = fifo_valid ? head.instr :
                           (bypass_hit ? fq.imem_rdata : NOP_INSTR);
  assign fq.pc_plus4_out = fifo_valid ? head.pc_plus4 :
                           (bypass_hit ? pc_q + 32'd4 : 32'd0);

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and randomized checks of fetch_queue against a queue-based model
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic reset;

  fetch_queue_if bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .fq    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;

  // Reference: a queue of fetched words, the fetch PC, and whether a request
  // is in flight and whether its answer is still wanted.
  ent_t        q[$];
  logic        m_busy;
  logic        m_stale;
  logic [31:0] m_pc;
  logic [31:0] m_addr;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy  = 1'b0;
    m_stale = 1'b0;
    m_pc    = RESET_PC;
    m_addr  = RESET_PC;
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the model to the state after the next rising edge.
  task automatic step(input logic h, input logic r, input logic [31:0] rpc, input logic a);
    logic        ack;
    logic        byp;
    logic        consume;
    logic        ev_valid;
    logic [31:0] ev_inst;
    logic [31:0] ev_pc4;
    logic [31:0] rdata;
    ent_t        e;
    @(negedge clk);
    rdata           = (a && m_busy) ? m_addr : $urandom();
    bus.hold        = h;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    bus.imem_ack    = a;
    bus.imem_rdata  = rdata;
    #1;
    ack = a && m_busy;
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (q.size() == 0) && ack && !m_stale;
`endif
    ev_valid = (q.size() > 0) || byp;
    ev_inst  = (q.size() > 0) ? q[0].instr : (byp ? rdata : 32'h0);
    ev_pc4   = (q.size() > 0) ? q[0].pc4 : (byp ? m_pc + 32'd4 : 32'h0);
    chk("imem_req", 32'(bus.imem_req), 32'(m_busy));
    if (m_busy) chk("imem_addr", bus.imem_addr, m_addr);
    chk("inst_valid", 32'(bus.inst_valid), 32'(ev_valid));
    chk("inst_out", bus.inst_out, ev_inst);
    chk("pc_plus4_out", bus.pc_plus4_out, ev_pc4);

    consume = ev_valid && !h && !r;
    if (r) begin
      q.delete();
      m_pc = rpc;
      if (m_busy) begin
        if (ack) begin
          m_stale = 1'b0;
          m_addr  = rpc;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else if (!m_busy) begin
      if (q.size() < DEPTH) begin
        m_busy = 1'b1;
        m_addr = m_pc;
      end
      if (consume) void'(q.pop_front());
    end else if (m_stale) begin
      if (ack) begin
        m_stale = 1'b0;
        m_addr  = m_pc;
      end
    end else begin
      if (consume && !byp) void'(q.pop_front());
      if (ack) begin
        if (!(byp && consume)) begin
          e.pc4   = m_pc + 32'd4;
          e.instr = rdata;
          q.push_back(e);
        end
        m_pc = m_pc + 32'd4;
        if (q.size() < DEPTH) m_addr = m_pc;
        else m_busy = 1'b0;
      end
    end
  endtask

  // Reset is raised mid-cycle so the outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_inst", bus.inst_out, 32'h0);
    chk("rst_pc4", bus.pc_plus4_out, 32'h0);
    bus.hold     = 1'b0;
    bus.redirect = 1'b0;
    bus.imem_ack = 1'b1;
    #4;
    reset        = 1'b1;
    bus.imem_ack = 1'b0;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset           = 1'b1;
    bus.hold        = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    model_reset();

    // zero-wait streaming
    do_reset();
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_same_cycle_valid", 32'(bus.inst_valid), 32'h1);
    chk("byp_same_cycle_inst", bus.inst_out, 32'h0);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
`else
    step(0, 0, 32'h0, 1);
    chk("zw_c2_inst", bus.inst_out, 32'h0);
    chk("zw_c2_pc4", bus.pc_plus4_out, 32'h4);
    step(0, 0, 32'h0, 1);
    chk("zw_c3_inst", bus.inst_out, 32'h4);
`endif
    repeat (6) step(0, 0, 32'h0, 1);

    // hold until full, then drain in order
    do_reset();
    repeat (10) step(1, 0, 32'h0, 1);
    chk("full_req", 32'(bus.imem_req), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'h0, 0);
      chk("full_pop_valid", 32'(bus.inst_valid), 32'h1);
      chk("full_pop_inst", bus.inst_out, 32'(4 * i));
    end

    // redirect in the second cycle of a slow request
    do_reset();
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    step(0, 1, 32'h100, 0);
    step(0, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);
    chk("drain_addr", bus.imem_addr, 32'h100);
    step(0, 0, 32'h0, 0);
    chk("drain_first_valid", 32'(bus.inst_valid), 32'h1);
    chk("drain_first_inst", bus.inst_out, 32'h100);

    // redirect and ack on the same edge
    do_reset();
    step(0, 0, 32'h0, 0);
    step(0, 1, 32'h200, 1);
    step(0, 0, 32'h0, 0);
    chk("redack_addr", bus.imem_addr, 32'h200);
    chk("redack_valid", 32'(bus.inst_valid), 32'h0);
    step(1, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);
    chk("redack_inst", bus.inst_out, 32'h200);

    // redirect overrides hold and flushes three buffered entries
    do_reset();
    step(1, 0, 32'h0, 0);
    repeat (3) step(1, 0, 32'h0, 1);
    step(1, 1, 32'h40, 0);
    step(1, 0, 32'h0, 0);
    chk("flush_valid", 32'(bus.inst_valid), 32'h0);
    chk("flush_inst", bus.inst_out, 32'h0);
    repeat (4) step(0, 0, 32'h0, 1);

    // fetch PC wrap at the top of the address space
    do_reset();
    step(0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 32'h0, 0);
    step(1, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);
    chk("wrap_inst", bus.inst_out, 32'hFFFF_FFFC);
    chk("wrap_pc4", bus.pc_plus4_out, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // randomized traffic with varying memory responsiveness
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      int ack_pct;
      ack_pct = 15 + seg * 12;
      for (int i = 0; i < 250; i++) begin
        logic [31:0] rpc;
        rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
        step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5), rpc,
             ($urandom_range(0, 99) < ack_pct));
      end
      if (seg == 3) begin
        while (!m_busy) step(0, 0, 32'h0, 0);
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
